// File: rtl/huff_pkg.sv
// Shared parameters and state encoding for the Huffman frequency-count stage.
package huff_pkg;
    localparam int K_MAX      = 20;
    localparam int SYM_W      = 8;
    localparam int FRQ_W      = 8;
    localparam int CNT_W      = 5;
    localparam int WDOG_LIMIT = 2 * K_MAX + 4;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT);

    typedef enum logic [1:0] {
        FEED,
        COLLECT,
        FLUSH,
        OUT
    } state_t;
endpackage

// File: rtl/freq_table.sv
// K_MAX-deep symbol/frequency register file: synchronous write, combinational read.
module freq_table
    import huff_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_waddr,
    input  logic [SYM_W-1:0] i_wsym,
    input  logic [FRQ_W-1:0] i_wfreq,
    input  logic [CNT_W-1:0] i_raddr,
    output logic [SYM_W-1:0] o_rsym,
    output logic [FRQ_W-1:0] o_rfreq
);
    logic [SYM_W+FRQ_W-1:0] w_rows [K_MAX];
    logic [SYM_W+FRQ_W-1:0] w_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < K_MAX; gi++) begin : g_row
            logic [SYM_W+FRQ_W-1:0] r_row;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_row <= '0;
                end else if (i_we && (i_waddr == CNT_W'(gi))) begin
                    r_row <= {i_wsym, i_wfreq};
                end
            end
            assign w_rows[gi] = r_row;
        end
    endgenerate

    // Addresses beyond the table read as zero rather than X.
    assign w_rdata = (i_raddr < CNT_W'(K_MAX)) ? w_rows[i_raddr] : '0;
    assign o_rsym  = w_rdata[SYM_W+FRQ_W-1:FRQ_W];
    assign o_rfreq = w_rdata[FRQ_W-1:0];
endmodule

// File: rtl/freq_count_ctrl.sv
// Feeds one K_MAX-byte frame into the frequency counter, captures its pulses,
// re-arms the counter and streams the captured table downstream.
module freq_count_ctrl
    import huff_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [SYM_W-1:0] i_in_data,
    output logic             o_cnt_rst_n,
    output logic             o_cnt_enb,
    output logic [SYM_W-1:0] o_cnt_data,
    input  logic             i_cnt_pulse,
    input  logic [SYM_W-1:0] i_cnt_syml,
    input  logic [FRQ_W-1:0] i_cnt_freq,
    input  logic             i_cnt_done,
    output logic             o_tbl_valid,
    input  logic             i_tbl_ready,
    output logic [SYM_W-1:0] o_tbl_sym,
    output logic [FRQ_W-1:0] o_tbl_freq,
    output logic             o_tbl_last,
    output logic [CNT_W-1:0] o_nsym,
    output logic             o_busy,
    output logic             o_err
);
    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_fed, w_fed_next;
    logic [CNT_W-1:0]    r_wr, w_wr_next;
    logic [CNT_W-1:0]    r_rd, w_rd_next;
    logic [WDOG_W-1:0]   r_wdog, w_wdog_next;
    logic                r_err, w_err_next;
    logic                r_done_q;
    logic                r_armed;
    logic                r_cnt_enb;
    logic [SYM_W-1:0]    r_cnt_data;

    logic                w_accept;
    logic                w_done_rise;
    logic                w_we;
    logic                w_last;
    logic                w_tbl_hs;
    logic [SYM_W-1:0]    w_rd_sym;
    logic [FRQ_W-1:0]    w_rd_freq;

    freq_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wr),
        .i_wsym  (i_cnt_syml),
        .i_wfreq (i_cnt_freq),
        .i_raddr (r_rd),
        .o_rsym  (w_rd_sym),
        .o_rfreq (w_rd_freq)
    );

    // r_armed keeps the block quiet until the first edge after reset release.
    assign o_in_ready  = r_armed && (r_state == FEED);
    assign o_cnt_rst_n = r_armed && (r_state != FLUSH);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_done_rise = i_cnt_done && !r_done_q;
    assign w_we        = (r_state == COLLECT) && i_cnt_pulse && (r_wr != CNT_W'(K_MAX));
    assign w_last      = (r_rd == (r_wr - CNT_W'(1)));
    assign w_tbl_hs    = o_tbl_valid && i_tbl_ready;

    always_comb begin
        w_state_next = r_state;
        w_fed_next   = r_fed;
        w_wr_next    = r_wr;
        w_rd_next    = r_rd;
        w_wdog_next  = r_wdog;
        w_err_next   = r_err;
        case (r_state)
            FEED: begin
                w_wdog_next = '0;
                if (w_accept) begin
                    if (r_fed == '0) begin
                        w_err_next = 1'b0;
                    end
                    if (r_fed == CNT_W'(K_MAX - 1)) begin
                        w_fed_next   = '0;
                        w_state_next = COLLECT;
                    end else begin
                        w_fed_next = r_fed + CNT_W'(1);
                    end
                end
            end
            COLLECT: begin
                if (w_we) begin
                    w_wr_next = r_wr + CNT_W'(1);
                end else if (i_cnt_pulse) begin
                    w_err_next = 1'b1;
                end
                if (w_done_rise) begin
                    w_state_next = FLUSH;
                end else if (r_wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
                    w_err_next   = 1'b1;
                    w_state_next = FLUSH;
                end else begin
                    w_wdog_next = r_wdog + WDOG_W'(1);
                end
            end
            FLUSH: begin
                if (r_wr == '0) begin
                    w_err_next   = 1'b1;
                    w_state_next = FEED;
                end else begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (w_tbl_hs) begin
                    if (w_last) begin
                        w_rd_next    = '0;
                        w_wr_next    = '0;
                        w_state_next = FEED;
                    end else begin
                        w_rd_next = r_rd + CNT_W'(1);
                    end
                end
            end
            default: w_state_next = FEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FEED;
            r_fed      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_wdog     <= '0;
            r_err      <= 1'b0;
            r_done_q   <= 1'b0;
            r_armed    <= 1'b0;
            r_cnt_enb  <= 1'b0;
            r_cnt_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fed      <= w_fed_next;
            r_wr       <= w_wr_next;
            r_rd       <= w_rd_next;
            r_wdog     <= w_wdog_next;
            r_err      <= w_err_next;
            r_done_q   <= i_cnt_done;
            r_armed    <= 1'b1;
            r_cnt_enb  <= w_accept;
            if (w_accept) begin
                r_cnt_data <= i_in_data;
            end
        end
    end

    assign o_cnt_enb   = r_cnt_enb;
    assign o_cnt_data  = r_cnt_data;
    assign o_tbl_valid = (r_state == OUT);
    assign o_tbl_sym   = o_tbl_valid ? w_rd_sym : '0;
    assign o_tbl_freq  = o_tbl_valid ? w_rd_freq : '0;
    assign o_tbl_last  = o_tbl_valid && w_last;
    assign o_nsym      = o_tbl_valid ? r_wr : '0;
    assign o_busy      = !((r_state == FEED) && (r_fed == '0));
    assign o_err       = r_err;
endmodule

// File: tb/tb_freq_count_ctrl.sv
// Self-checking bench: stub frequency counter plus a histogram reference model.
module tb_freq_count_ctrl;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       cnt_rst_n, cnt_enb;
    logic [7:0] cnt_data;
    logic       cnt_pulse, cnt_done;
    logic [7:0] cnt_syml, cnt_freq;
    logic       tbl_valid, tbl_ready, tbl_last;
    logic [7:0] tbl_sym, tbl_freq;
    logic [4:0] nsym;
    logic       busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    freq_count_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_cnt_rst_n (cnt_rst_n),
        .o_cnt_enb   (cnt_enb),
        .o_cnt_data  (cnt_data),
        .i_cnt_pulse (cnt_pulse),
        .i_cnt_syml  (cnt_syml),
        .i_cnt_freq  (cnt_freq),
        .i_cnt_done  (cnt_done),
        .o_tbl_valid (tbl_valid),
        .i_tbl_ready (tbl_ready),
        .o_tbl_sym   (tbl_sym),
        .o_tbl_freq  (tbl_freq),
        .o_tbl_last  (tbl_last),
        .o_nsym      (nsym),
        .o_busy      (busy),
        .o_err       (err)
    );

    // Stub counter: counts enabled bytes, then pulses each distinct symbol once
    // in first-seen order and raises a sticky done.
    bit      stub_withhold = 0;
    bit      stub_same     = 0;
    int      enb_count     = 0;
    int      rstlow_count  = 0;
    int      st_hist [256];
    byte_q_t st_order;
    int      st_seen;
    int      st_phase;
    logic [7:0] st_sym;

    initial begin
        cnt_pulse = 0; cnt_syml = 0; cnt_freq = 0; cnt_done = 0;
        st_seen = 0; st_phase = 0;
        foreach (st_hist[i]) st_hist[i] = 0;
        forever begin
            @(posedge clk); #1;
            cnt_pulse = 0;
            if (!rst_n || !cnt_rst_n) begin
                if (rst_n) rstlow_count++;
                st_order.delete();
                foreach (st_hist[i]) st_hist[i] = 0;
                st_seen = 0; st_phase = 0; cnt_done = 0;
            end else begin
                if (st_phase == 1) begin
                    st_sym    = st_order.pop_front();
                    cnt_pulse = 1;
                    cnt_syml  = st_sym;
                    cnt_freq  = 8'(st_hist[st_sym]);
                    if (st_order.size() == 0) begin
                        st_phase = 2;
                        if (stub_same && !stub_withhold) cnt_done = 1;
                    end
                end else if (st_phase == 2) begin
                    if (!stub_withhold) cnt_done = 1;
                end
                if (cnt_enb) begin
                    enb_count++;
                    if (st_hist[cnt_data] == 0) st_order.push_back(cnt_data);
                    st_hist[cnt_data]++;
                    st_seen++;
                    if (st_seen == 20) st_phase = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bytes(input byte_q_t b, input bit gaps, input bit err_clear);
        int w;
        foreach (b[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 0;
                    @(posedge clk); #2;
                end
            end
            if (err_clear && i == 0) chk("err_before_accept", err, 1);
            in_valid = 1;
            in_data  = b[i];
            w = 0;
            while (in_ready !== 1 && w < 100) begin
                @(posedge clk); #2; w++;
            end
            if (w >= 100) chk("in_ready_timeout", in_ready, 1);
            @(posedge clk); #2;
            if (err_clear && i == 0) chk("err_cleared", err, 0);
        end
        in_valid = 0;
    endtask

    task automatic drain(input byte_q_t es, input int ef[$], input int stall_idx);
        int idx, w, stall;
        w = 0;
        while (tbl_valid !== 1 && w < 300) begin
            @(posedge clk); #2; w++;
        end
        chk("tbl_valid_wait", tbl_valid, 1);
        if (tbl_valid !== 1) return;
        idx = 0; stall = 7; w = 0;
        while (idx < es.size() && w < 400) begin
            if (idx == stall_idx && stall > 0) begin
                tbl_ready = 0; stall--;
            end else begin
                tbl_ready = 1;
            end
            chk("tbl_valid", tbl_valid, 1);
            chk("tbl_sym", tbl_sym, es[idx]);
            chk("tbl_freq", tbl_freq, ef[idx]);
            chk("tbl_last", tbl_last, (idx == es.size() - 1));
            chk("nsym", nsym, es.size());
            chk("busy_out", busy, 1);
            if (tbl_ready) idx++;
            @(posedge clk); #2; w++;
        end
        tbl_ready = 0;
        chk("drain_done", idx, es.size());
        chk("tbl_valid_after", tbl_valid, 0);
    endtask

    task automatic run_frame(input byte_q_t b, input bit gaps, input int stall_idx,
                             input bit withhold, input bit err_clear);
        byte_q_t es;
        int      ef[$];
        int      found, k;
        // Reference: histogram in order of first appearance.
        foreach (b[i]) begin
            found = -1;
            foreach (es[j]) if (es[j] == b[i]) found = j;
            if (found < 0) begin
                es.push_back(b[i]); ef.push_back(1);
            end else begin
                ef[found]++;
            end
        end
        enb_count = 0; rstlow_count = 0; stub_withhold = withhold;
        send_bytes(b, gaps, err_clear);
        if (withhold) begin
            k = 0;
            while (cnt_rst_n === 1 && k < 200) begin
                k++; @(posedge clk); #2;
            end
            chk("wdog_cycles", k, 2 * 20 + 4);
            chk("wdog_err", err, 1);
        end
        drain(es, ef, stall_idx);
        stub_withhold = 0;
        chk("enb_count", enb_count, 20);
        chk("rst_pulses", rstlow_count, 1);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("err_end", err, withhold);
        $display("frame: %0d bytes, %0d entries, errors so far %0d", b.size(), es.size(), errors);
    endtask

    initial begin
        byte_q_t b;
        int      j;
        logic [7:0] t;

        rst_n = 0; in_valid = 0; in_data = 0; tbl_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cnt_enb", cnt_enb, 0);
        chk("rst_cnt_data", cnt_data, 0);
        chk("rst_cnt_rst_n", cnt_rst_n, 0);
        chk("rst_tbl_valid", tbl_valid, 0);
        chk("rst_tbl_sym", tbl_sym, 0);
        chk("rst_tbl_freq", tbl_freq, 0);
        chk("rst_tbl_last", tbl_last, 0);
        chk("rst_nsym", nsym, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #2;
        chk("armed_cnt_rst_n", cnt_rst_n, 1);
        chk("armed_in_ready", in_ready, 1);

        // 20 x 0x41, no gaps.
        b.delete();
        repeat (20) b.push_back(8'h41);
        run_frame(b, 0, -1, 0, 0);

        // 10x05, 5x07, 5x09 shuffled, random gaps, done rises with last pulse.
        b.delete();
        repeat (10) b.push_back(8'h05);
        repeat (5)  b.push_back(8'h07);
        repeat (5)  b.push_back(8'h09);
        for (int i = 19; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = b[i]; b[i] = b[j]; b[j] = t;
        end
        stub_same = 1;
        run_frame(b, 1, -1, 0, 0);
        stub_same = 0;

        // 0x00..0x13 with a 7-cycle tbl_ready stall mid-stream.
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'(i));
        run_frame(b, 0, 10, 0, 0);

        // Counter never reports done: watchdog path.
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom_range(0, 7)));
        run_frame(b, 1, -1, 1, 0);

        // Next frame clears err on its first accept.
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom_range(0, 5)));
        run_frame(b, 1, $urandom_range(0, 2), 0, 1);

        // Reset mid-frame after 12 accepts.
        b.delete();
        for (int i = 0; i < 12; i++) b.push_back(8'($urandom_range(0, 255)));
        send_bytes(b, 0, 0);
        rst_n = 0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cnt_rst_n", cnt_rst_n, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt_enb", cnt_enb, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #2;
        b.delete();
        repeat (20) b.push_back(8'h22);
        run_frame(b, 0, -1, 0, 0);

        // Back-to-back frames plus a few random ones.
        for (int f = 0; f < 4; f++) begin
            b.delete();
            for (int i = 0; i < 20; i++) b.push_back(8'($urandom_range(0, 15)));
            run_frame(b, (f >= 2), -1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
